// File: rtl/vec_xfer_seq.sv
// rtl/vec_xfer_seq.sv - base+stride vector load/store sequencer between system memory and vector register file
// One element is issued per clock; the opposite side of each element completes one cycle later.
module vec_xfer_seq #(
  parameter int DW        = 16,
  parameter int AW        = 16,
  parameter int VLEN      = 16,
  parameter int VRW       = 3,
  parameter int STRIDE_EN = 1
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic                    Start,
  input  logic                    Mode,
  input  logic [VRW-1:0]          VReg,
  input  logic [AW-1:0]           Base,
  input  logic [7:0]              Stride,
  output logic                    Busy,
  output logic                    Done,
  output logic                    Err,
  output logic [AW-1:0]           Addr,
  output logic                    RD,
  output logic                    WR,
  output logic [DW-1:0]           DataOut,
  input  logic [DW-1:0]           DataIn,
  output logic [VRW-1:0]          vAddr,
  output logic [$clog2(VLEN)-1:0] vIdx,
  output logic                    vRD,
  output logic                    vWR,
  output logic [DW-1:0]           vWData,
  input  logic [DW-1:0]           vRData
);

  localparam int IW = $clog2(VLEN);
  localparam int CW = $clog2(VLEN + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t        state;
  logic          modeR;
  logic [7:0]    strideR;
  logic [AW-1:0] issueAddr;
  logic [CW-1:0] cnt;
  logic [AW:0]   nextSum;
  logic          lastIssued;
  logic [IW-1:0] curIdx;
  logic [IW-1:0] prevIdx;

  // cnt is the number of elements already issued, so it also names the next element
  always_comb begin
    nextSum    = {1'b0, issueAddr} + (AW+1)'(strideR);
    lastIssued = (cnt == CW'(VLEN));
    curIdx     = IW'(cnt);
    prevIdx    = IW'(cnt - 1'b1);
  end

  // Returned data passes straight through in the cycle after the read strobe
  assign vWData  = vWR ? DataIn : '0;
  assign DataOut = WR  ? vRData : '0;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state     <= IDLE;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Err       <= 1'b0;
      RD        <= 1'b0;
      WR        <= 1'b0;
      vRD       <= 1'b0;
      vWR       <= 1'b0;
      Addr      <= '0;
      vIdx      <= '0;
      vAddr     <= '0;
      modeR     <= 1'b0;
      strideR   <= '0;
      issueAddr <= '0;
      cnt       <= '0;
    end else begin
      RD   <= 1'b0;
      WR   <= 1'b0;
      vRD  <= 1'b0;
      vWR  <= 1'b0;
      Done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (Start) begin
            state     <= ISSUE;
            Busy      <= 1'b1;
            Err       <= 1'b0;
            modeR     <= Mode;
            vAddr     <= VReg;
            strideR   <= (STRIDE_EN != 0) ? Stride : 8'd1;
            issueAddr <= Base;
            cnt       <= CW'(1);
            if (Mode) begin
              vRD  <= 1'b1;
              vIdx <= '0;
            end else begin
              RD   <= 1'b1;
              Addr <= Base;
            end
          end else begin
            state <= IDLE;
          end
        end
        ISSUE: begin
          // Complete the element issued last cycle
          if (modeR) begin
            WR   <= 1'b1;
            Addr <= issueAddr;
          end else begin
            vWR  <= 1'b1;
            vIdx <= prevIdx;
          end
          if (lastIssued) begin
            state <= DRAIN;
          end else begin
            issueAddr <= nextSum[AW-1:0];
            cnt       <= cnt + 1'b1;
            if (nextSum[AW]) Err <= 1'b1;
            if (modeR) begin
              vRD  <= 1'b1;
              vIdx <= curIdx;
            end else begin
              RD   <= 1'b1;
              Addr <= nextSum[AW-1:0];
            end
          end
        end
        DRAIN: begin
          state <= DONE;
          Busy  <= 1'b0;
          Done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vec_xfer_seq.sv
// tb/tb_vec_xfer_seq.sv - scoreboard testbench for vec_xfer_seq
module tb_vec_xfer_seq;

  localparam int DW = 16, AW = 16, VLEN = 16, VRW = 3, IW = 4;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic           Reset_n, Start, Mode;
  logic [VRW-1:0] VReg;
  logic [AW-1:0]  Base;
  logic [7:0]     Stride;
  logic           Busy, Done, Err, RD, WR, vRD, vWR;
  logic [AW-1:0]  Addr;
  logic [DW-1:0]  DataOut, vWData;
  logic [DW-1:0]  DataIn = '0;
  logic [DW-1:0]  vRData = '0;
  logic [VRW-1:0] vAddr;
  logic [IW-1:0]  vIdx;

  logic           start0;
  logic           busy0, done0, err0, rd0, wr0, vrd0, vwr0;
  logic [AW-1:0]  addr0;
  logic [DW-1:0]  dataOut0, vWData0;
  logic [DW-1:0]  dataIn0 = '0;
  logic [DW-1:0]  vRData0 = '0;
  logic [VRW-1:0] vAddr0;
  logic [IW-1:0]  vIdx0;

  vec_xfer_seq #(.DW(DW), .AW(AW), .VLEN(VLEN), .VRW(VRW), .STRIDE_EN(1)) u_dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Mode(Mode), .VReg(VReg), .Base(Base),
    .Stride(Stride), .Busy(Busy), .Done(Done), .Err(Err), .Addr(Addr), .RD(RD), .WR(WR),
    .DataOut(DataOut), .DataIn(DataIn), .vAddr(vAddr), .vIdx(vIdx), .vRD(vRD), .vWR(vWR),
    .vWData(vWData), .vRData(vRData)
  );

  vec_xfer_seq #(.DW(DW), .AW(AW), .VLEN(VLEN), .VRW(VRW), .STRIDE_EN(0)) u_dut0 (
    .Clk(Clk), .Reset_n(Reset_n), .Start(start0), .Mode(Mode), .VReg(VReg), .Base(Base),
    .Stride(Stride), .Busy(busy0), .Done(done0), .Err(err0), .Addr(addr0), .RD(rd0), .WR(wr0),
    .DataOut(dataOut0), .DataIn(dataIn0), .vAddr(vAddr0), .vIdx(vIdx0), .vRD(vrd0), .vWR(vwr0),
    .vWData(vWData0), .vRData(vRData0)
  );

  logic [DW-1:0] mem   [0:65535];
  logic [DW-1:0] vfile [0:127];

  int cyc = 0;
  always @(posedge Clk) begin
    cyc <= cyc + 1;
    if (RD)  DataIn  <= mem[Addr];
    if (vRD) vRData  <= vfile[{vAddr, vIdx}];
    if (rd0) dataIn0 <= mem[addr0];
  end

  typedef struct { int cyc; bit wr; logic [AW-1:0] addr; logic [DW-1:0] data; } mem_ev_t;
  typedef struct { int cyc; bit wr; logic [VRW-1:0] vreg; logic [IW-1:0] idx; logic [DW-1:0] data; } vec_ev_t;

  mem_ev_t memQ[$];
  vec_ev_t vecQ[$];
  int      checks = 0;
  int      errors = 0;
  bit      monOn  = 1'b0;

  // Cycle c of a transfer whose start edge left cyc at p is observed with cyc == p + c - 1
  task automatic pushXfer(input bit mode, input logic [VRW-1:0] vr, input logic [AW-1:0] base,
                          input logic [7:0] stride, input int p);
    logic [AW-1:0] a;
    logic [IW-1:0] kk;
    mem_ev_t m;
    vec_ev_t v;
    a = base;
    for (int k = 0; k < VLEN; k++) begin
      kk = IW'(k);
      if (!mode) begin
        m = '{p + k, 1'b0, a, 16'h0};
        v = '{p + k + 1, 1'b1, vr, kk, mem[a]};
      end else begin
        v = '{p + k, 1'b0, vr, kk, 16'h0};
        m = '{p + k + 1, 1'b1, a, vfile[{vr, kk}]};
      end
      memQ.push_back(m);
      vecQ.push_back(v);
      a = a + AW'(stride);
    end
  endtask

  task automatic startXfer(input bit mode, input logic [VRW-1:0] vr, input logic [AW-1:0] base,
                           input logic [7:0] stride, output int p);
    Start  = 1'b1;
    Mode   = mode;
    VReg   = vr;
    Base   = base;
    Stride = stride;
    p = cyc + 1;
    pushXfer(mode, vr, base, stride, p);
    @(posedge Clk);
    #1;
    Start = 1'b0;
  endtask

  task automatic waitDone(input int p, input bit expErr, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge Clk);
      if (Done) seen = 1'b1;
      else begin
        checks++;
        if (Busy !== 1'b1) begin
          errors++;
          $display("FAIL %s busy: got %b want 1 at cyc %0d", name, Busy, cyc);
        end
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s done_timeout: got no Done want Done at cyc %0d", name, p + VLEN + 1);
    end else begin
      checks++;
      if (cyc !== p + VLEN + 1) begin
        errors++;
        $display("FAIL %s done_cycle: got cyc %0d want %0d", name, cyc, p + VLEN + 1);
      end
      checks++;
      if (Busy !== 1'b0 || Err !== expErr) begin
        errors++;
        $display("FAIL %s done_flags: got Busy=%b Err=%b want Busy=0 Err=%b", name, Busy, Err, expErr);
      end
      checks++;
      if (memQ.size() != 0 || vecQ.size() != 0) begin
        errors++;
        $display("FAIL %s drained: got %0d/%0d pending want 0/0", name, memQ.size(), vecQ.size());
      end
    end
  endtask

  task automatic monitor();
    mem_ev_t m;
    vec_ev_t v;
    forever begin
      @(negedge Clk);
      if (monOn) begin
        checks++;
        if ((RD && WR) || (vRD && vWR)) begin
          errors++;
          $display("FAIL strobe_excl: got RD=%b WR=%b vRD=%b vWR=%b want no pair", RD, WR, vRD, vWR);
        end
        if (RD || WR) begin
          checks++;
          if (memQ.size() == 0) begin
            errors++;
            $display("FAIL mem_unexpected: got RD=%b WR=%b Addr=%h at cyc %0d want none", RD, WR, Addr, cyc);
          end else begin
            m = memQ.pop_front();
            if (cyc !== m.cyc || WR !== m.wr || Addr !== m.addr || (m.wr && DataOut !== m.data)) begin
              errors++;
              $display("FAIL mem_access: got cyc=%0d WR=%b Addr=%h Data=%h want cyc=%0d WR=%b Addr=%h Data=%h",
                       cyc, WR, Addr, DataOut, m.cyc, m.wr, m.addr, m.data);
            end
          end
        end
        if (vRD || vWR) begin
          checks++;
          if (vecQ.size() == 0) begin
            errors++;
            $display("FAIL vec_unexpected: got vRD=%b vWR=%b idx=%0d at cyc %0d want none", vRD, vWR, vIdx, cyc);
          end else begin
            v = vecQ.pop_front();
            if (cyc !== v.cyc || vWR !== v.wr || vAddr !== v.vreg || vIdx !== v.idx ||
                (v.wr && vWData !== v.data)) begin
              errors++;
              $display("FAIL vec_access: got cyc=%0d vWR=%b reg=%0d idx=%0d data=%h want cyc=%0d vWR=%b reg=%0d idx=%0d data=%h",
                       cyc, vWR, vAddr, vIdx, vWData, v.cyc, v.wr, v.vreg, v.idx, v.data);
            end
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    checks++;
    if ({Busy, Done, Err, RD, WR, vRD, vWR} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 0000000", {Busy, Done, Err, RD, WR, vRD, vWR});
    end
    checks++;
    if (Addr !== 16'h0 || DataOut !== 16'h0 || vWData !== 16'h0 || vIdx !== 4'h0 || vAddr !== 3'h0) begin
      errors++;
      $display("FAIL reset_buses: got Addr=%h DO=%h vWD=%h vIdx=%0d vAddr=%0d want all 0",
               Addr, DataOut, vWData, vIdx, vAddr);
    end
    Reset_n = 1'b1;
    @(negedge Clk);
  endtask

  task automatic test_load();
    int p;
    for (int i = 0; i < 16; i++) mem[16'h0100 + i] = 16'hA000 + 16'(i);
    startXfer(1'b0, 3'd3, 16'h0100, 8'd1, p);
    waitDone(p, 1'b0, "load");
    @(negedge Clk);
  endtask

  task automatic test_store();
    int p;
    for (int i = 0; i < 16; i++) vfile[{3'd5, 4'(i)}] = 16'(16'h1111 * i);
    startXfer(1'b1, 3'd5, 16'h0200, 8'd3, p);
    waitDone(p, 1'b0, "store");
    @(negedge Clk);
  endtask

  task automatic test_wrap();
    int p;
    for (int i = 0; i < 16; i++) mem[16'(16'hFFF8 + i)] = 16'hB000 + 16'(i);
    startXfer(1'b0, 3'd2, 16'hFFF8, 8'd1, p);
    waitDone(p, 1'b1, "wrap");
    @(negedge Clk);
    checks++;
    if (Err !== 1'b1) begin
      errors++;
      $display("FAIL wrap_sticky: got Err=%b want 1", Err);
    end
    startXfer(1'b0, 3'd2, 16'h0300, 8'd2, p);
    @(negedge Clk);
    checks++;
    if (Err !== 1'b0) begin
      errors++;
      $display("FAIL wrap_clear: got Err=%b want 0", Err);
    end
    waitDone(p, 1'b0, "wrap_next");
    @(negedge Clk);
  endtask

  task automatic test_back_to_back();
    int p, p2;
    startXfer(1'b0, 3'd1, 16'h0400, 8'd1, p);
    repeat (4) @(negedge Clk);
    @(negedge Clk);
    Start = 1'b1; Mode = 1'b1; Base = 16'h9999; Stride = 8'd7; VReg = 3'd6;
    @(negedge Clk);
    Start = 1'b0;
    repeat (3) @(negedge Clk);
    @(negedge Clk);
    Start = 1'b1; Base = 16'h1234;
    @(negedge Clk);
    Start = 1'b0;
    waitDone(p, 1'b0, "start_ignored");
    startXfer(1'b1, 3'd5, 16'h0500, 8'd1, p2);
    @(negedge Clk);
    checks++;
    if (vRD !== 1'b1 || cyc !== p2) begin
      errors++;
      $display("FAIL b2b_first: got vRD=%b cyc=%0d want vRD=1 cyc=%0d", vRD, cyc, p2);
    end
    waitDone(p2, 1'b0, "back_to_back");
    @(negedge Clk);
  endtask

  task automatic test_stride0();
    int p;
    mem[16'h0777] = 16'hC0DE;
    startXfer(1'b0, 3'd4, 16'h0777, 8'd0, p);
    waitDone(p, 1'b0, "stride0");
    @(negedge Clk);
  endtask

  task automatic test_reset_mid();
    int p;
    bit bad;
    monOn = 1'b0;
    startXfer(1'b1, 3'd5, 16'h0600, 8'd1, p);
    repeat (6) @(negedge Clk);
    Reset_n = 1'b0;
    @(negedge Clk);
    checks++;
    if ({Busy, Done, RD, WR, vRD, vWR} !== 6'b0 || Addr !== 16'h0) begin
      errors++;
      $display("FAIL reset_mid: got flags=%b Addr=%h want 000000 0000", {Busy, Done, RD, WR, vRD, vWR}, Addr);
    end
    Reset_n = 1'b1;
    bad = 1'b0;
    repeat (25) begin
      @(negedge Clk);
      if (Done || RD || WR || vRD || vWR || Busy) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL reset_quiet: got activity after abort want none");
    end
    memQ.delete();
    vecQ.delete();
    monOn = 1'b1;
  endtask

  task automatic test_stride_en0();
    bit ok;
    Mode = 1'b0; VReg = 3'd1; Base = 16'h0800; Stride = 8'd9;
    start0 = 1'b1;
    @(posedge Clk);
    #1;
    start0 = 1'b0;
    for (int c = 1; c <= VLEN; c++) begin
      @(negedge Clk);
      checks++;
      if (rd0 !== 1'b1 || addr0 !== 16'h0800 + 16'(c - 1)) begin
        errors++;
        $display("FAIL stride_en0_addr: got RD=%b Addr=%h want RD=1 Addr=%h", rd0, addr0, 16'h0800 + 16'(c - 1));
      end
    end
    @(negedge Clk);
    checks++;
    if (vwr0 !== 1'b1 || vIdx0 !== 4'd15 || vWData0 !== mem[16'h080F]) begin
      errors++;
      $display("FAIL stride_en0_last: got vWR=%b idx=%0d data=%h want 1 15 %h", vwr0, vIdx0, vWData0, mem[16'h080F]);
    end
    @(negedge Clk);
    ok = (done0 === 1'b1) && (busy0 === 1'b0) && (err0 === 1'b0);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL stride_en0_done: got Done=%b Busy=%b Err=%b want 1 0 0", done0, busy0, err0);
    end
  endtask

  initial begin
    Reset_n = 1'b0; Start = 1'b0; start0 = 1'b0; Mode = 1'b0; VReg = '0; Base = '0; Stride = '0;
    for (int i = 0; i < 65536; i++) mem[i] = 16'(i) ^ 16'h5A5A;
    for (int i = 0; i < 128; i++) vfile[i] = 16'(i) ^ 16'h3C3C;
    @(negedge Clk);
    test_reset();
    fork
      monitor();
    join_none
    monOn = 1'b1;
    test_load();
    test_store();
    test_wrap();
    test_back_to_back();
    test_stride0();
    test_reset_mid();
    test_stride_en0();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
